// File: rtl/usb_ep_out_trans_fifo_if.sv
// OUT-endpoint transaction FIFO bus: protocol-engine push side and application pop side.
interface usb_ep_out_trans_fifo_if #(
    parameter int unsigned EP_DATA_WID = 8
);
    logic                   EP_OUT_dataValid_i;
    logic [EP_DATA_WID-1:0] EP_OUT_data_i;
    logic                   EP_OUT_fillTransDone_i;
    logic                   EP_OUT_fillTransSuccess_i;
    logic                   EP_OUT_full_o;
    logic                   appDataValid_o;
    logic [EP_DATA_WID-1:0] appData_o;
    logic                   appPop_i;
    logic                   overflow_o;

    modport master (
        output EP_OUT_dataValid_i, EP_OUT_data_i, EP_OUT_fillTransDone_i,
               EP_OUT_fillTransSuccess_i, appPop_i,
        input  EP_OUT_full_o, appDataValid_o, appData_o, overflow_o
    );

    modport slave (
        input  EP_OUT_dataValid_i, EP_OUT_data_i, EP_OUT_fillTransDone_i,
               EP_OUT_fillTransSuccess_i, appPop_i,
        output EP_OUT_full_o, appDataValid_o, appData_o, overflow_o
    );
endinterface

// File: rtl/usb_ep_out_trans_fifo.sv
// OUT-endpoint FIFO with tentative writes: bytes become visible to the application
// only when the transaction ends successfully; failed or overflowed transactions roll back.
module usb_ep_out_trans_fifo #(
    parameter int unsigned EP_DATA_WID = 8,
    parameter int unsigned DEPTH       = 64
) (
    input  logic                     clk48_i,
    input  logic                     rst_n_i,
    usb_ep_out_trans_fifo_if.slave   bus
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;

    logic [EP_DATA_WID-1:0] r_mem [DEPTH];
    logic [PW-1:0]          r_rd_ptr;
    logic [PW-1:0]          r_commit_ptr;
    logic [PW-1:0]          r_wr_ptr;
    logic                   r_overflow;

    logic                   w_full;
    logic                   w_valid;
    logic                   w_push;
    logic                   w_ovf_set;
    logic                   w_pop;
    logic                   w_commit;
    logic [PW-1:0]          w_wr_next;

    always_comb begin
        w_full    = (r_wr_ptr - r_rd_ptr) == PW'(DEPTH);
        w_valid   = (r_rd_ptr != r_commit_ptr);
        w_push    = bus.EP_OUT_dataValid_i & ~w_full;
        w_ovf_set = bus.EP_OUT_dataValid_i & w_full;
        w_pop     = bus.appPop_i & w_valid;
        w_wr_next = r_wr_ptr + PW'(w_push);
        // An overflow raised in the same cycle as Done still forces a rollback.
        w_commit  = bus.EP_OUT_fillTransSuccess_i & ~(r_overflow | w_ovf_set);
    end

    always_ff @(posedge clk48_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_rd_ptr     <= '0;
            r_commit_ptr <= '0;
            r_wr_ptr     <= '0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (bus.EP_OUT_fillTransDone_i) begin
                r_overflow <= 1'b0;
                if (w_commit) begin
                    r_commit_ptr <= w_wr_next;
                    r_wr_ptr     <= w_wr_next;
                end else begin
                    r_wr_ptr     <= r_commit_ptr;
                end
            end else begin
                r_wr_ptr   <= w_wr_next;
                r_overflow <= r_overflow | w_ovf_set;
            end
        end
    end

    // Storage is not reset; a push into a slot that is rolled back is harmless.
    always_ff @(posedge clk48_i) begin
        if (w_push) begin
            r_mem[r_wr_ptr[AW-1:0]] <= bus.EP_OUT_data_i;
        end
    end

    always_comb begin
        bus.EP_OUT_full_o  = w_full;
        bus.appDataValid_o = w_valid;
        bus.appData_o      = r_mem[r_rd_ptr[AW-1:0]];
        bus.overflow_o     = r_overflow;
    end
endmodule

// File: tb/tb_usb_ep_out_trans_fifo.sv
// Bench for usb_ep_out_trans_fifo at DEPTH=4: directed scenarios plus random traffic,
// checked against a queue-based model of committed and tentative bytes.
module tb_usb_ep_out_trans_fifo;
    localparam int unsigned DW = 8;
    localparam int unsigned DP = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    logic [DW-1:0] m_commit[$];
    logic [DW-1:0] m_tent[$];
    logic          m_ovf = 1'b0;

    usb_ep_out_trans_fifo_if #(.EP_DATA_WID(DW)) bus ();

    usb_ep_out_trans_fifo #(.EP_DATA_WID(DW), .DEPTH(DP)) dut (
        .clk48_i (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("full", 32'(bus.EP_OUT_full_o), 32'((m_commit.size() + m_tent.size()) == DP));
        chk("valid", 32'(bus.appDataValid_o), 32'(m_commit.size() != 0));
        chk("overflow", 32'(bus.overflow_o), 32'(m_ovf));
        if (m_commit.size() != 0)
            chk("data", 32'(bus.appData_o), 32'(m_commit[0]));
    endtask

    // One clock cycle: check current outputs, apply inputs, advance model at the edge.
    task automatic step(input logic dv, input logic [DW-1:0] d, input logic done,
                        input logic succ, input logic pop);
        bit full_now, ovf_now;
        check_model();
        bus.EP_OUT_dataValid_i        = dv;
        bus.EP_OUT_data_i             = d;
        bus.EP_OUT_fillTransDone_i    = done;
        bus.EP_OUT_fillTransSuccess_i = succ;
        bus.appPop_i                  = pop;
        @(posedge clk);
        full_now = (m_commit.size() + m_tent.size()) == DP;
        ovf_now  = 1'b0;
        if (pop && m_commit.size() != 0) void'(m_commit.pop_front());
        if (dv) begin
            if (!full_now) m_tent.push_back(d);
            else           ovf_now = 1'b1;
        end
        if (done) begin
            if (succ && !(m_ovf || ovf_now))
                while (m_tent.size() != 0) m_commit.push_back(m_tent.pop_front());
            m_tent.delete();
            m_ovf = 1'b0;
        end else begin
            m_ovf = m_ovf | ovf_now;
        end
        #1;
        bus.EP_OUT_dataValid_i     = 1'b0;
        bus.EP_OUT_fillTransDone_i = 1'b0;
        bus.appPop_i               = 1'b0;
    endtask

    task automatic pop_expect(input logic [DW-1:0] b);
        chk("pop_valid", 32'(bus.appDataValid_o), 32'd1);
        chk("pop_data", 32'(bus.appData_o), 32'(b));
        step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        bus.EP_OUT_dataValid_i        = 1'b0;
        bus.EP_OUT_data_i             = '0;
        bus.EP_OUT_fillTransDone_i    = 1'b0;
        bus.EP_OUT_fillTransSuccess_i = 1'b0;
        bus.appPop_i                  = 1'b0;
        #12;
        chk("rst_full", 32'(bus.EP_OUT_full_o), 32'd0);
        chk("rst_valid", 32'(bus.appDataValid_o), 32'd0);
        chk("rst_ovf", 32'(bus.overflow_o), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Commit of three bytes, visible one cycle after Done
        step(1'b1, 8'h11, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h33, 1'b0, 1'b0, 1'b0);
        chk("tentative_hidden", 32'(bus.appDataValid_o), 32'd0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        pop_expect(8'h11); pop_expect(8'h22); pop_expect(8'h33);
        chk("drained", 32'(bus.appDataValid_o), 32'd0);

        // Rollback
        step(1'b1, 8'hAA, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        pop_expect(8'hAA); pop_expect(8'h03);
        chk("rollback_empty", 32'(bus.appDataValid_o), 32'd0);

        // Overflow forces rollback even with Success
        for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b0);
        chk("ovf_full", 32'(bus.EP_OUT_full_o), 32'd1);
        step(1'b1, 8'h44, 1'b0, 1'b0, 1'b0);
        chk("ovf_set", 32'(bus.overflow_o), 32'd1);
        step(1'b0, '0, 1'b1, 1'b1, 1'b0);
        chk("ovf_valid", 32'(bus.appDataValid_o), 32'd0);
        chk("ovf_clr", 32'(bus.overflow_o), 32'd0);
        chk("ovf_notfull", 32'(bus.EP_OUT_full_o), 32'd0);

        // Pointer wrap over three rounds
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 3; i++) step(1'b1, 8'(r * 16 + i + 1), 1'b0, 1'b0, 1'b0);
            step(1'b0, '0, 1'b1, 1'b1, 1'b0);
            chk("wrap_full", 32'(bus.EP_OUT_full_o), 32'd0);
            for (int i = 0; i < 3; i++) pop_expect(8'(r * 16 + i + 1));
        end

        // Same-cycle push with Done
        step(1'b1, 8'h55, 1'b1, 1'b1, 1'b0);
        pop_expect(8'h55);
        step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
        chk("sim_discard", 32'(bus.appDataValid_o), 32'd0);
        for (int i = 0; i < 3; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h63, 1'b1, 1'b1, 1'b0);
        chk("sim_full", 32'(bus.EP_OUT_full_o), 32'd1);
        step(1'b1, 8'h66, 1'b0, 1'b0, 1'b1);
        chk("sim_pop_frees", 32'(bus.EP_OUT_full_o), 32'd0);
        step(1'b0, '0, 1'b1, 1'b0, 1'b0);
        pop_expect(8'h61); pop_expect(8'h62); pop_expect(8'h63);

        // Asynchronous reset mid-transaction
        step(1'b1, 8'hA5, 1'b1, 1'b1, 1'b0);
        step(1'b1, 8'h01, 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'h02, 1'b0, 1'b0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_full", 32'(bus.EP_OUT_full_o), 32'd0);
        chk("arst_valid", 32'(bus.appDataValid_o), 32'd0);
        chk("arst_ovf", 32'(bus.overflow_o), 32'd0);
        m_commit.delete(); m_tent.delete(); m_ovf = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        step(1'b1, 8'h7E, 1'b1, 1'b1, 1'b0);
        pop_expect(8'h7E);

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 9) < 6), 8'($urandom), 1'($urandom_range(0, 9) == 0),
                 1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 9) < 4));
        end
        check_model();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/usb_ep_out_trans_fifo.md
USB_EP_OUT_TRANS_FIFO -- requirements
Module: usb_ep_out_trans_fifo

Interface
REQ-001 SHALL have parameter EP_DATA_WID, default 8, meaning data byte width.
REQ-002 SHALL have parameter DEPTH, default 64, meaning number of entries (power of two, >= 4).
REQ-003 SHALL have port clk48_i, input, 1, meaning the single clock; all logic is rising-edge.
REQ-004 SHALL have port rst_n_i, input, 1, meaning asynchronous active-low reset.
REQ-005 SHALL have port EP_OUT_dataValid_i, input, 1, meaning the protocol engine pushes EP_OUT_data_i this cycle.
REQ-006 SHALL have port EP_OUT_data_i, input, EP_DATA_WID, meaning the OUT payload byte.
REQ-007 SHALL have port EP_OUT_fillTransDone_i, input, 1, meaning a single-cycle pulse that ends the current OUT transaction.
REQ-008 SHALL have port EP_OUT_fillTransSuccess_i, input, 1, meaning commit (1) or discard (0), sampled with fillTransDone.
REQ-009 SHALL have port EP_OUT_full_o, output, 1, meaning no free entry for a tentative write.
REQ-010 SHALL have port appDataValid_o, output, 1, meaning committed data is available at appData_o.
REQ-011 SHALL have port appData_o, output, EP_DATA_WID, meaning the oldest committed byte (first-word fall-through).
REQ-012 SHALL have port appPop_i, input, 1, meaning the application consumes appData_o when appDataValid_o=1.
REQ-013 SHALL have port overflow_o, output, 1, meaning a sticky flag set by a push while full, cleared by the next fillTransDone.

Function
REQ-014 SHALL keep the pointers rdPtr, commitPtr and wrPtr, each log2(DEPTH)+1 bits wide; the MSB is the wrap bit and addressing uses the low bits.
REQ-015 SHALL write mem[wrPtr] and increment wrPtr by 1 on a push (dataValid=1 and full=0), with the write visible to the app side only after commit.
REQ-016 SHALL drive EP_OUT_full_o = ((wrPtr - rdPtr) == DEPTH), combinationally from registered pointers.
REQ-017 SHALL ignore a push while full, leave memory and wrPtr unchanged, and set overflow to 1.
REQ-018 SHALL, on fillTransDone=1 with success=1 and overflow=0, set commitPtr to the post-push wrPtr, so a push in the same cycle is included.
REQ-019 SHALL, on fillTransDone=1 with success=0 or overflow=1 (including an overflow raised in that same cycle), set wrPtr to commitPtr, discarding the same-cycle push, and leave commitPtr unchanged.
REQ-020 SHALL clear overflow on every fillTransDone pulse, with the clear overriding a same-cycle set.
REQ-021 SHALL drive appDataValid_o = (rdPtr != commitPtr) and appData_o = mem[rdPtr[low]], both combinational.
REQ-022 SHALL increment rdPtr on appPop_i=1 with appDataValid_o=1, and ignore appPop_i when appDataValid_o=0.
REQ-023 SHALL allow a push and a pop in the same cycle; the pop frees a slot that is visible from the next cycle.
REQ-024 SHALL make a commit visible on appDataValid_o exactly 1 cycle after the fillTransDone edge.
REQ-025 SHALL wrap pointer arithmetic modulo 2*DEPTH without any special casing.
REQ-026 SHALL treat a fillTransDone with zero pushes in the transaction as a no-op apart from clearing overflow.

Reset
REQ-027 SHALL, on rst_n_i=0, immediately set rdPtr=commitPtr=wrPtr=0 and overflow=0, giving EP_OUT_full_o=0 and appDataValid_o=0.
REQ-028 SHALL not reset memory contents, and appData_o is don't-care while appDataValid_o=0.
REQ-029 SHALL, if reset is asserted mid-transaction, lose all tentative and committed data, with the first push after release writing entry 0.

Verification
REQ-030 SHALL cover commit: push 0x11,0x22,0x33 then Done+Success -> appDataValid_o=1 one cycle later; pops return 0x11,0x22,0x33; then appDataValid_o=0.
REQ-031 SHALL cover rollback: commit 0xAA; push 0x01,0x02; Done+!Success -> only 0xAA is readable; the next commit of 0x03 reads 0xAA,0x03.
REQ-032 SHALL cover overflow: DEPTH=4, push 5 bytes -> full=1 after the 4th and overflow=1 after the 5th; Done+Success -> rollback, appDataValid_o=0, overflow=0.
REQ-033 SHALL cover wrap: 3 rounds of 3-byte commit/drain at DEPTH=4 -> data intact across the pointer wrap, full never asserted.
REQ-034 SHALL cover simultaneous events: push 0x55 together with Done+Success -> 0x55 is committed; push with Done+!Success -> 0x55 is discarded; push plus pop at full -> full=0 next cycle.
REQ-035 SHALL cover mid-operation reset: rst_n_i low during a 2-byte tentative fill with 1 committed byte -> outputs are 0 asynchronously; after release, a push 0x7E plus commit reads 0x7E.
